// File: rtl/sequence_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package sequence_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] SEQ_DEFAULT = 4'b1011;

endpackage

// File: rtl/seq_piso.sv
// Loadable parallel-in/serial-out shift register with a one-hot position marker
// that flags the last serial slot of a repetition (LEN slots per repetition).
module seq_piso #(
  parameter int SEQ_W = 4,
  parameter int LEN   = SEQ_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             clear_i,
  input  logic [SEQ_W-1:0] pattern_i,
  input  logic             ser_i,
  output logic             msb_o,
  output logic             last_o
);

  logic [SEQ_W-1:0] sr_q, sr_d;
  logic [LEN-1:0]   mark_q, mark_d;

  always_comb begin
    sr_d   = sr_q;
    mark_d = mark_q;
    if (clear_i) begin
      sr_d   = '0;
      mark_d = '0;
    end else if (load_i) begin
      sr_d   = pattern_i;
      mark_d = {{(LEN-1){1'b0}}, 1'b1};
    end else if (shift_i) begin
      // ser_i fills from the bottom; it reaches the MSB after SEQ_W shifts
      sr_d   = {sr_q[SEQ_W-2:0], ser_i};
      mark_d = {mark_q[LEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '0;
      mark_q <= '0;
    end else begin
      sr_q   <= sr_d;
      mark_q <= mark_d;
    end
  end

  assign msb_o  = sr_q[SEQ_W-1];
  assign last_o = mark_q[LEN-1];

endmodule

// File: rtl/sequence_gen.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, repeat_n times,
// with optional idle gaps. Define SEQUENCE_GEN_PARITY_EN to append an even-parity bit.
module sequence_gen
  import sequence_pkg::*;
#(
  parameter int SEQ_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SEQ_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap,
  output logic             data,
  output logic             valid,
  output logic             busy,
  output logic             done
);

`ifdef SEQUENCE_GEN_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int LEN = SEQ_W + PAR_BITS;

  state_t           state_q;
  logic [SEQ_W-1:0] pat_q;
  logic [CNT_W-1:0] rep_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gcnt_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  logic             load_d;
  logic             shift_d;
  logic             clear_d;
  logic [SEQ_W-1:0] load_pat_d;
  logic             ser_d;
  logic             last_bit;
  logic             more_reps;

`ifdef SEQUENCE_GEN_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      par_q <= ^pattern;
    end
  end

  assign ser_d = par_q;
`else
  assign ser_d = 1'b0;
`endif

  assign more_reps = (rep_q > CNT_W'(1));

  // Shift-register control for the coming edge
  always_comb begin
    load_d     = 1'b0;
    shift_d    = 1'b0;
    clear_d    = 1'b0;
    load_pat_d = pat_q;
    case (state_q)
      IDLE: begin
        if (start && repeat_n != '0) begin
          load_d     = 1'b1;
          load_pat_d = pattern;
        end
      end
      SEND: begin
        if (!last_bit) begin
          shift_d = 1'b1;
        end else if (more_reps && gap_q == '0) begin
          load_d = 1'b1;
        end else begin
          clear_d = 1'b1;
        end
      end
      GAP: begin
        if (gcnt_q == GAP_W'(1)) begin
          load_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  seq_piso #(
    .SEQ_W(SEQ_W),
    .LEN  (LEN)
  ) u_piso (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load_d),
    .shift_i  (shift_d),
    .clear_i  (clear_d),
    .pattern_i(load_pat_d),
    .ser_i    (ser_d),
    .msb_o    (data),
    .last_o   (last_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            pat_q  <= pattern;
            rep_q  <= repeat_n;
            gap_q  <= gap;
            busy_q <= 1'b1;
            if (repeat_n == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= SEND;
              valid_q <= 1'b1;
            end
          end
        end
        SEND: begin
          if (last_bit) begin
            rep_q <= rep_q - CNT_W'(1);
            if (!more_reps) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else if (gap_q != '0) begin
              state_q <= GAP;
              gcnt_q  <= gap_q;
              valid_q <= 1'b0;
            end
          end
        end
        GAP: begin
          gcnt_q <= gcnt_q - GAP_W'(1);
          if (gcnt_q == GAP_W'(1)) begin
            state_q <= SEND;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_sequence_gen.sv
// Bench for sequence_gen: directed and random transfers checked cycle by cycle
// against an expected {busy,valid,data,done} stream built from the transfer rules.
module tb_sequence_gen;
  import sequence_pkg::*;

  localparam int SEQ_W = 4;
  localparam int CNT_W = 4;
  localparam int GAP_W = 4;
`ifdef SEQUENCE_GEN_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [SEQ_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_n;
  logic [GAP_W-1:0] gap;
  logic             data, valid, busy, done;

  int vectors = 0;
  int errors  = 0;
  logic [3:0] exp_q[$];

  sequence_gen #(.SEQ_W(SEQ_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pattern (pattern),
    .repeat_n(repeat_n),
    .gap     (gap),
    .data    (data),
    .valid   (valid),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Expected per-cycle outputs {busy,valid,data,done} following acceptance
  function automatic void build(input logic [SEQ_W-1:0] pat, input int r, input int g);
    int ones;
    exp_q.delete();
    ones = 0;
    for (int j = 0; j < SEQ_W; j++) ones += int'(pat[j]);
    for (int k = 0; k < r; k++) begin
      for (int i = SEQ_W - 1; i >= 0; i--) exp_q.push_back({1'b1, 1'b1, pat[i], 1'b0});
      if (PB == 1) exp_q.push_back({1'b1, 1'b1, ones[0], 1'b0});
      if (k < r - 1)
        for (int c = 0; c < g; c++) exp_q.push_back(4'b1000);
    end
    exp_q.push_back(4'b1001);
  endfunction

  task automatic check(input string tag, input logic [3:0] exp);
    vectors++;
    assert ({busy, valid, data, done} === exp)
    else begin
      errors++;
      $error("FAIL %s: observed busy/valid/data/done=%b expected %b", tag,
             {busy, valid, data, done}, exp);
    end
  endtask

  task automatic run(input string tag, input logic [SEQ_W-1:0] pat,
                     input logic [CNT_W-1:0] r, input logic [GAP_W-1:0] g,
                     input bit repulse);
    @(negedge clk);
    pattern  = pat;
    repeat_n = r;
    gap      = g;
    start    = 1'b1;
    build(pat, int'(r), int'(g));
    @(negedge clk);
    start    = 1'b0;
    pattern  = SEQ_W'($urandom);
    repeat_n = CNT_W'($urandom);
    gap      = GAP_W'($urandom);
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s[%0d]", tag, i), exp_q[i]);
      if (repulse && i == 2) begin
        start    = 1'b1;
        pattern  = 4'b0110;
        repeat_n = CNT_W'(1);
        gap      = '0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check($sformatf("%s_idle", tag), 4'b0000);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    pattern  = '0;
    repeat_n = '0;
    gap      = '0;
    repeat (2) @(negedge clk);
    check("reset", 4'b0000);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset", 4'b0000);

    run("single", SEQ_DEFAULT, 4'd1, 4'd0, 1'b0);
    run("rep3_gap2", SEQ_DEFAULT, 4'd3, 4'd2, 1'b0);
    run("rep0", SEQ_DEFAULT, 4'd0, 4'd3, 1'b0);
    run("repulse", SEQ_DEFAULT, 4'd1, 4'd0, 1'b1);
    run("rep2_b2b", 4'b0110, 4'd2, 4'd0, 1'b0);

    // Abort during the third bit
    @(negedge clk);
    pattern  = SEQ_DEFAULT;
    repeat_n = 4'd1;
    gap      = 4'd0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort_b0", 4'b1110);
    @(negedge clk);
    check("abort_b1", 4'b1100);
    @(negedge clk);
    check("abort_b2", 4'b1110);
    rst = 1'b1;
    @(negedge clk);
    check("abort_rst", 4'b0000);
    rst = 1'b0;
    @(negedge clk);
    check("abort_nodone0", 4'b0000);
    @(negedge clk);
    check("abort_nodone1", 4'b0000);
    run("after_abort", SEQ_DEFAULT, 4'd1, 4'd1, 1'b0);

`ifdef SEQUENCE_GEN_PARITY_EN
    run("parity", SEQ_DEFAULT, 4'd2, 4'd0, 1'b0);
`endif

    for (int t = 0; t < 25; t++) begin
      run($sformatf("rnd%0d", t), SEQ_W'($urandom_range(0, 15)),
          CNT_W'($urandom_range(0, 5)), GAP_W'($urandom_range(0, 3)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
